// File: rtl/axi_lite_led_ctrl_if.sv
// AXI4-Lite slave-side bundle for the LED controller.
// Ports: write address (AWADDR/AWVALID/AWREADY), write data (WDATA/WSTRB/WVALID/WREADY),
//        write response (BRESP/BVALID/BREADY), read address (ARADDR/ARVALID/ARREADY),
//        read data (RDATA/RRESP/RVALID/RREADY).
interface axi_lite_led_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_led_ctrl.sv
// AXI4-Lite LED controller: DATA (0x0), MODE (0x4), BLINK_DIV (0x8), ID (0xC, RO).
// Ports: ACLK, ARESETn (synchronous, active-low), s_axi (slave modport), led_o (registered).
// Optional feature macro: LED_CTRL_BLINK_EN builds MODE, BLINK_DIV and the blink prescaler;
// without it MODE/BLINK_DIV read 0, ignore writes, and led_o follows DATA.
module axi_lite_led_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LED_WIDTH  = 8,
    parameter logic [31:0] DIV_RESET  = 32'h0000_FFFF
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_lite_led_ctrl_if.slave    s_axi,
    output logic [LED_WIDTH-1:0]  led_o
);
    localparam logic [31:0] ID_VALUE    = 32'h4C45_4400;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [LED_WIDTH-1:0]  data_q, data_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
`ifdef LED_CTRL_BLINK_EN
    logic [LED_WIDTH-1:0]  mode_q, mode_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  div_wr;
`endif

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] cur_awaddr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_wstrb;
    logic [31:0]           rd_val;
    logic                  unused_c;

    // Byte-lane merge of write data into an existing register value
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign aw_hs      = s_axi.S_AXI_AWVALID && awready_q;
    assign w_hs       = s_axi.S_AXI_WVALID && wready_q;
    assign ar_hs      = s_axi.S_AXI_ARVALID && arready_q;
    // Held value wins; otherwise take the beat arriving this cycle
    assign cur_awaddr = aw_held_q ? aw_addr_q : s_axi.S_AXI_AWADDR;
    assign cur_wdata  = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
    assign cur_wstrb  = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
    assign commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    // Address bits [1:0] and lanes above LED_WIDTH are intentionally ignored
    assign unused_c   = ^{cur_awaddr[1:0], s_axi.S_AXI_ARADDR[1:0], cur_wdata, cur_wstrb};

    // Register read mux, always returning pre-write contents
    always_comb begin
        rd_val = 32'd0;
        case (s_axi.S_AXI_ARADDR[3:2])
            2'd0: rd_val = 32'(data_q);
`ifdef LED_CTRL_BLINK_EN
            2'd1: rd_val = 32'(mode_q);
            2'd2: rd_val = div_q;
`endif
            2'd3: rd_val = ID_VALUE;
            default: rd_val = 32'd0;
        endcase
    end

    // Write path: independent AW/W capture, commit, B response
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        data_d    = data_q;
`ifdef LED_CTRL_BLINK_EN
        mode_d    = mode_q;
        div_d     = div_q;
        div_wr    = 1'b0;
`endif
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if ((cur_awaddr >> 4) != '0) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
                case (cur_awaddr[3:2])
                    2'd0: data_d = LED_WIDTH'(strb_merge(32'(data_q), cur_wdata, cur_wstrb));
`ifdef LED_CTRL_BLINK_EN
                    2'd1: mode_d = LED_WIDTH'(strb_merge(32'(mode_q), cur_wdata, cur_wstrb));
                    2'd2: begin
                        div_d  = strb_merge(div_q, cur_wdata, cur_wstrb);
                        div_wr = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

`ifdef LED_CTRL_BLINK_EN
    // Blink prescaler; a BLINK_DIV write restarts it from phase 0
    always_comb begin
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
        if (div_wr) begin
            cnt_d   = 32'd0;
            phase_d = 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_d   = 32'd0;
            phase_d = !phase_q;
        end
        led_d = (data_q & ~mode_q) | (mode_q & {LED_WIDTH{phase_q}});
    end
`else
    always_comb begin
        led_d = data_q;
    end
`endif

    // Read FSM next state and registered outputs
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    if ((s_axi.S_AXI_ARADDR >> 4) != '0) begin
                        rdata_d = 32'd0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rdata_d = rd_val;
                        rresp_d = RESP_OKAY;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Read FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Write path, register file and LED flops
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            data_q    <= '0;
            led_q     <= '0;
`ifdef LED_CTRL_BLINK_EN
            mode_q    <= '0;
            div_q     <= DIV_RESET;
            cnt_q     <= 32'd0;
            phase_q   <= 1'b0;
`endif
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            data_q    <= data_d;
            led_q     <= led_d;
`ifdef LED_CTRL_BLINK_EN
            mode_q    <= mode_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
`endif
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign led_o               = led_q;
endmodule

// File: tb/tb_axi_lite_led_ctrl.sv
// Scoreboarded bench for axi_lite_led_ctrl: responses are predicted from a register-map
// model at issue time and compared by a monitor when B/R handshakes occur.
module tb_axi_lite_led_ctrl;
    localparam int unsigned AW     = 12;
    localparam int unsigned LW     = 8;
    localparam logic [31:0] DIVR   = 32'h0000_FFFF;
    localparam logic [31:0] ID_VAL = 32'h4C45_4400;
`ifdef LED_CTRL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] led;
    int unsigned   cyc   = 0;
    int            checks   = 0;
    int            failures = 0;
    bit            hold_b   = 1'b0;

    logic [1:0]    bq[$];
    logic [33:0]   rq[$];

    logic [LW-1:0] m_data;
    logic [LW-1:0] m_mode;
    logic [31:0]   m_div;

    logic [AW-1:0] addr_tab [8] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                    12'h010, 12'h014, 12'h104, 12'h800};

    axi_lite_led_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    axi_lite_led_ctrl #(
        .ADDR_WIDTH(AW),
        .LED_WIDTH (LW),
        .DIV_RESET (DIVR)
    ) dut (
        .ACLK   (clk),
        .ARESETn(rst_n),
        .s_axi  (bus),
        .led_o  (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready drivers: random back-pressure unless B is deliberately stalled
    always @(posedge clk) begin
        #2;
        bus.S_AXI_BREADY = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus.S_AXI_RREADY = ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_mode = '0;
        m_div  = DIVR;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        logic [1:0] sel;
        sel = a[3:2];
        if ((a >> 4) != 0) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            if (sel == 2'd0) m_data = LW'(merge(32'(m_data), d, s));
            if (sel == 2'd1 && BLINK) m_mode = LW'(merge(32'(m_mode), d, s));
            if (sel == 2'd2 && BLINK) m_div = merge(m_div, d, s);
        end
    endtask

    function automatic logic [33:0] model_read(input logic [AW-1:0] a);
        logic [1:0] sel;
        sel = a[3:2];
        if ((a >> 4) != 0) return {2'b10, 32'h0};
        case (sel)
            2'd0:    return {2'b00, 32'(m_data)};
            2'd1:    return {2'b00, 32'(m_mode)};
            2'd2:    return {2'b00, BLINK ? m_div : 32'h0};
            default: return {2'b00, ID_VAL};
        endcase
    endfunction

    // Expected LED pattern given a blink phase
    function automatic logic [LW-1:0] exp_led(input bit ph);
        return (m_data & ~m_mode) | (m_mode & {LW{ph}});
    endfunction

    // Write; W leads AW by 'lead' cycles. hs = cycle of the final (committing) handshake.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, output int unsigned hs);
        logic [1:0] resp;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int k = 0;
        model_write(a, d, s, resp);
        bq.push_back(resp);
        hs = cyc;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_AWVALID = (lead == 0);
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (w_done && !aw_done) check("w_held_wready", 32'(bus.S_AXI_WREADY), 32'd0);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) begin aw_done = 1'b1; hs = cyc; end
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) begin w_done = 1'b1; hs = cyc; end
            @(posedge clk);
            #1;
            k++;
            if (aw_done) bus.S_AXI_AWVALID = 1'b0;
            if (w_done)  bus.S_AXI_WVALID  = 1'b0;
            if (!aw_done && k >= lead) bus.S_AXI_AWVALID = 1'b1;
            if (k > 300) begin
                checks++;
                failures++;
                $display("FAIL write_timeout addr=%h", a);
                bus.S_AXI_AWVALID = 1'b0;
                bus.S_AXI_WVALID  = 1'b0;
                break;
            end
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a);
        bit done = 1'b0;
        int k = 0;
        rq.push_back(model_read(a));
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) done = 1'b1;
            @(posedge clk);
            #1;
            k++;
            if (done) bus.S_AXI_ARVALID = 1'b0;
            if (k > 300) begin
                checks++;
                failures++;
                $display("FAIL read_timeout addr=%h", a);
                bus.S_AXI_ARVALID = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((bq.size() != 0 || rq.size() != 0) && k < 400) begin
            step(1);
            k++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: b_pending=%0d r_pending=%0d", bq.size(), rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    // Monitor: compare each B/R handshake against the oldest prediction
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (rst_n) begin
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected: got bresp %h with nothing pending", bus.S_AXI_BRESP);
                end else begin
                    eb = bq.pop_front();
                    check("bresp", 32'(bus.S_AXI_BRESP), 32'(eb));
                end
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected: got rdata %h with nothing pending", bus.S_AXI_RDATA);
                end else begin
                    er = rq.pop_front();
                    check("rdata", bus.S_AXI_RDATA, er[31:0]);
                    check("rresp", 32'(bus.S_AXI_RRESP), 32'(er[33:32]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        model_reset();

        // Reset values
        step(3);
        @(negedge clk);
        check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
        check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
        check("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
        check("rst_led",     32'(led),               32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        check("post_rst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
        check("post_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

        // Full write to DATA, LED two cycles after the handshake
        axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0, hs);
        check("bvalid_n1", 32'(bus.S_AXI_BVALID), 32'd1);
        step(1);
        check("led_ff_n2", 32'(led), 32'(exp_led(1'b0)));
        axi_read(12'h000);

        // Strobe 0 leaves DATA alone, strobe 1 updates byte 0
        axi_write(12'h000, 32'h0000_00A5, 4'h0, 0, hs);
        step(1);
        check("led_strb0", 32'(led), 32'(exp_led(1'b0)));
        axi_write(12'h000, 32'h0000_00A5, 4'h1, 0, hs);
        step(1);
        check("led_strb1", 32'(led), 32'(exp_led(1'b0)));
        drain();

        // W leads AW by 3 cycles; B stalled 5 cycles
        hold_b = 1'b1;
        step(1);
        axi_write(12'h000, 32'h0000_005A, 4'hF, 3, hs);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
            check("hold_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
            check("hold_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
            step(1);
        end
        hold_b = 1'b0;
        drain();
        check("led_after_hold", 32'(led), 32'(exp_led(1'b0)));

        // ID, decode errors, no change on out-of-range write
        axi_read(12'h00C);
        axi_read(12'h010);
        axi_write(12'h010, 32'h0000_0077, 4'hF, 0, hs);
        axi_read(12'h000);
        drain();

        // Blink pattern after BLINK_DIV restart
        axi_write(12'h000, 32'h0000_00F0, 4'hF, 0, hs);
        axi_write(12'h004, 32'h0000_000F, 4'hF, 1, hs);
        axi_write(12'h008, 32'h0000_0003, 4'hF, 0, hs);
        for (int j = 1; j <= 17; j++) begin
            bit ph;
            step(1);
            ph = 1'(((longint'(j) - 1) / (longint'(m_div) + 1)) % 2);
            check("blink_led", 32'(led), 32'(exp_led(ph)));
        end
        axi_read(12'h004);
        axi_read(12'h008);
        drain();

        // Randomized traffic against the register model
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = addr_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), hs);
            end else begin
                axi_read(a);
            end
        end
        axi_read(12'h000);
        axi_read(12'h004);
        axi_read(12'h008);
        drain();

        // Reset while a B response is pending
        hold_b = 1'b1;
        step(1);
        axi_write(12'h000, 32'h0000_003C, 4'hF, 0, hs);
        step(1);
        @(negedge clk);
        check("pre_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        bq.delete();
        model_reset();
        @(negedge clk);
        check("mid_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        check("mid_rst_led",    32'(led),              32'd0);
        hold_b = 1'b0;
        step(2);
        axi_read(12'h000);
        axi_read(12'h008);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
